// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the I/D memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned ARB_ADDR_W_DEF      = 32;
  localparam int unsigned ARB_DATA_W_DEF      = 32;
  localparam int unsigned ARB_MAX_DSTREAK_DEF = 4;
  localparam int unsigned ARB_TIMEOUT_DEF     = 255;
  localparam int unsigned ARB_TCNT_W          = 16;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Pipeline-side (I/D) and memory-side signals of the shared-memory arbiter.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              IReq;
  logic [ADDR_W-1:0] IAddr;
  logic [DATA_W-1:0] IRdata;
  logic              IReady;

  logic              DReq;
  logic              DWe;
  logic [ADDR_W-1:0] DAddr;
  logic [DATA_W-1:0] DWdata;
  logic [DATA_W-1:0] DRdata;
  logic              DReady;

  logic              MemReq;
  logic              MemWe;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWdata;
  logic [DATA_W-1:0] MemRdata;
  logic              MemValid;

  logic              Err;

  // Arbiter view
  modport slave (
    input  IReq, IAddr, DReq, DWe, DAddr, DWdata, MemRdata, MemValid,
    output IRdata, IReady, DRdata, DReady, MemReq, MemWe, MemAddr, MemWdata, Err
  );

  // Requester / memory view
  modport master (
    output IReq, IAddr, DReq, DWe, DAddr, DWdata, MemRdata, MemValid,
    input  IRdata, IReady, DRdata, DReady, MemReq, MemWe, MemAddr, MemWdata, Err
  );

endinterface

// File: rtl/mem_arbiter_watchdog.sv
// Clear/load/enable counter with a terminal-count flag; holds once terminal is reached.
module mem_arbiter_watchdog #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned TERM  = 254
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             ld_i,
  input  logic [CNT_W-1:0] ld_val_i,
  input  logic             en_i,
  output logic             tc_c_o
);

  localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(TERM);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_term_c;

  assign at_term_c = (cnt_q == TERM_VAL);
  assign tc_c_o    = en_i & at_term_c;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (ld_i) begin
      cnt_d = ld_val_i;
    end else if (en_i && !at_term_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between fetch (I) and memory-stage (D) requesters:
// one transaction at a time, D priority with a fetch starvation guard, response watchdog.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = ARB_ADDR_W_DEF,
  parameter int unsigned DATA_W      = ARB_DATA_W_DEF,
  parameter int unsigned MAX_DSTREAK = ARB_MAX_DSTREAK_DEF,
  parameter int unsigned TIMEOUT     = ARB_TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam int unsigned     SW          = $clog2(MAX_DSTREAK + 2);
  localparam logic [SW-1:0]   DSTREAK_MAX = SW'(MAX_DSTREAK);

  arb_state_e        state_q, state_d;
  grant_e            gnt_q, gnt_d;
  logic [SW-1:0]     dstreak_q, dstreak_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] irdata_q, irdata_d;
  logic [DATA_W-1:0] drdata_q, drdata_d;
  logic              iready_q, iready_d;
  logic              dready_q, dready_d;
  logic              err_q, err_d;

  logic              busy_c;
  logic              tmo_c;
  logic              contested_c;
  logic              pick_i_c;
  logic              upd_rdata_c;
  logic [DATA_W-1:0] rsp_data_c;

  assign busy_c      = (state_q == ARB_BUSY);
  assign contested_c = bus.IReq & bus.DReq;
  // D has priority unless it has won MAX_DSTREAK contested grants in a row
  assign pick_i_c    = bus.IReq & (~bus.DReq | (dstreak_q == DSTREAK_MAX));
  // Timed-out accesses return zero; acknowledged writes leave read data alone
  assign upd_rdata_c = ~bus.MemValid | ~mem_we_q;
  assign rsp_data_c  = bus.MemValid ? bus.MemRdata : '0;

  mem_arbiter_watchdog #(
    .CNT_W (ARB_TCNT_W),
    .TERM  (TIMEOUT - 1)
  ) u_wdog (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (~busy_c),
    .ld_i     (1'b0),
    .ld_val_i ('0),
    .en_i     (busy_c),
    .tc_c_o   (tmo_c)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    dstreak_d   = dstreak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    irdata_d    = irdata_q;
    drdata_d    = drdata_q;
    iready_d    = 1'b0;
    dready_d    = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (bus.IReq || bus.DReq) begin
          state_d   = ARB_BUSY;
          mem_req_d = 1'b1;
          if (pick_i_c) begin
            gnt_d      = GNT_I;
            mem_we_d   = 1'b0;
            mem_addr_d = bus.IAddr;
            dstreak_d  = '0;
          end else begin
            gnt_d       = GNT_D;
            mem_we_d    = bus.DWe;
            mem_addr_d  = bus.DAddr;
            mem_wdata_d = bus.DWdata;
            if (contested_c && (dstreak_q != DSTREAK_MAX)) begin
              dstreak_d = dstreak_q + SW'(1);
            end
          end
        end
      end

      ARB_BUSY: begin
        // An ack on the terminal cycle wins over the timeout
        if (bus.MemValid || tmo_c) begin
          state_d   = ARB_RESP;
          mem_req_d = 1'b0;
          err_d     = ~bus.MemValid;
          if (gnt_q == GNT_I) begin
            iready_d = 1'b1;
            if (upd_rdata_c) irdata_d = rsp_data_c;
          end else begin
            dready_d = 1'b1;
            if (upd_rdata_c) drdata_d = rsp_data_c;
          end
        end
      end

      ARB_RESP: begin
        state_d = ARB_IDLE;
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= GNT_I;
      dstreak_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      irdata_q    <= '0;
      drdata_q    <= '0;
      iready_q    <= 1'b0;
      dready_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      dstreak_q   <= dstreak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      irdata_q    <= irdata_d;
      drdata_q    <= drdata_d;
      iready_q    <= iready_d;
      dready_q    <= dready_d;
      err_q       <= err_d;
    end
  end

  assign bus.MemReq   = mem_req_q;
  assign bus.MemWe    = mem_we_q;
  assign bus.MemAddr  = mem_addr_q;
  assign bus.MemWdata = mem_wdata_q;
  assign bus.IRdata   = irdata_q;
  assign bus.IReady   = iready_q;
  assign bus.DRdata   = drdata_q;
  assign bus.DReady   = dready_q;
  assign bus.Err      = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, corner-case sequences and
// randomized rounds checked against a transaction-level model.
module tb_mem_arbiter;

  localparam int unsigned TMO  = 8;
  localparam int unsigned MAXD = 4;

  typedef struct {
    bit          i_on;
    bit          d_on;
    bit          d_we;
    logic [31:0] i_addr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] i_data;
    logic [31:0] d_data;
    int          i_lat;
    int          d_lat;
  } round_t;

  typedef struct {
    logic [31:0] rdata;
    int          cycles;
    bit          err;
  } exp_t;

  typedef struct {
    round_t r;
    bit     is_i;
    exp_t   e;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic mv_auto;
  logic mv_stray;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model state
  int          m_streak;
  logic [31:0] m_irdata;
  logic [31:0] m_drdata;

  int          lat_tab [logic [31:0]];
  logic [31:0] dat_tab [logic [31:0]];

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(MAXD), .TIMEOUT(TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  assign bus.MemValid = mv_auto | mv_stray;

  // Memory: acks after lat_tab[addr] BUSY cycles (-1 = never)
  initial begin
    int cnt;
    int lat;
    cnt = 0;
    lat = 0;
    mv_auto = 1'b0;
    bus.MemRdata = '0;
    forever begin
      @(posedge clk); #1;
      if (reset || !bus.MemReq) begin
        cnt = 0;
        mv_auto = 1'b0;
        bus.MemRdata = 32'hFFFF_FFFF;
      end else begin
        if (cnt == 0) lat = lat_tab.exists(bus.MemAddr) ? lat_tab[bus.MemAddr] : 0;
        cnt++;
        mv_auto = (lat >= 0) && (cnt == lat + 1);
        bus.MemRdata = mv_auto ? (dat_tab.exists(bus.MemAddr) ? dat_tab[bus.MemAddr] : 32'h5A5A_5A5A)
                               : 32'hFFFF_FFFF;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_pick_i(input bit i_on, input bit d_on);
    if (!d_on) return 1'b1;
    if (!i_on) return 1'b0;
    return (m_streak == int'(MAXD));
  endfunction

  function automatic void model_note(input bit won_i, input bit contested);
    if (won_i) m_streak = 0;
    else if (contested && m_streak < int'(MAXD)) m_streak++;
  endfunction

  function automatic exp_t model_exp(input bit is_i, input bit we, input logic [31:0] data, input int lat);
    exp_t e;
    bit   to;
    to = (lat < 0) || (lat >= int'(TMO));
    e.cycles = to ? int'(TMO) : lat + 1;
    e.err    = to;
    if (to)                e.rdata = 32'h0;
    else if (!is_i && we)  e.rdata = m_drdata;
    else                   e.rdata = data;
    return e;
  endfunction

  function automatic vec_t mk(input bit is_i, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] data, input int lat,
                              input logic [31:0] exp_rd, input int exp_cyc, input bit exp_err);
    vec_t v;
    v.r.i_on = is_i;      v.r.d_on = !is_i;     v.r.d_we = we;
    v.r.i_addr = addr;    v.r.d_addr = addr;    v.r.d_wdata = wdata;
    v.r.i_data = data;    v.r.d_data = data;
    v.r.i_lat = lat;      v.r.d_lat = lat;
    v.is_i = is_i;
    v.e.rdata = exp_rd;   v.e.cycles = exp_cyc; v.e.err = exp_err;
    return v;
  endfunction

  // Drive one or two requests, each held until its Ready, and check every completion
  task automatic run_round(input round_t r, input bit first_i, input exp_t e1, input exp_t e2, input string tag);
    int   n_exp, done, cyc, rise, cnt, last_rdy;
    bit   prev_mr, cur_i;
    exp_t e;
    n_exp = int'(r.i_on) + int'(r.d_on);
    done = 0; cyc = 0; rise = -1; cnt = 0; last_rdy = -1; prev_mr = 1'b0;
    if (r.i_on) begin lat_tab[r.i_addr] = r.i_lat; dat_tab[r.i_addr] = r.i_data; end
    if (r.d_on) begin lat_tab[r.d_addr] = r.d_lat; dat_tab[r.d_addr] = r.d_data; end
    bus.IReq = r.i_on;  bus.IAddr = r.i_addr;
    bus.DReq = r.d_on;  bus.DWe = r.d_we; bus.DAddr = r.d_addr; bus.DWdata = r.d_wdata;
    while (done < n_exp && cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
      cur_i = (done == 0) ? first_i : !first_i;
      e     = (done == 0) ? e1 : e2;
      if (bus.MemReq && !prev_mr) begin
        rise = cyc; cnt = 0;
        chk({tag, ".memaddr"}, bus.MemAddr, cur_i ? r.i_addr : r.d_addr);
        chk({tag, ".memwe"}, 32'(bus.MemWe), cur_i ? 32'h0 : 32'(r.d_we));
        if (!cur_i && r.d_we) chk({tag, ".memwdata"}, bus.MemWdata, r.d_wdata);
        if (done == 0) chk({tag, ".req_lat"}, 32'(rise), 32'd1);
        else           chk({tag, ".regrant_gap"}, 32'(rise - last_rdy), 32'd2);
      end
      if (bus.MemReq) cnt++;
      prev_mr = bus.MemReq;
      if (bus.IReady || bus.DReady) begin
        chk({tag, ".ready_side"}, 32'({bus.IReady, bus.DReady}), cur_i ? 32'd2 : 32'd1);
        chk({tag, ".memreq_cycles"}, 32'(cnt), 32'(e.cycles));
        chk({tag, ".resp_lat"}, 32'(cyc - rise), 32'(e.cycles));
        chk({tag, ".err"}, 32'(bus.Err), 32'(e.err));
        if (cur_i) begin
          chk({tag, ".irdata"}, bus.IRdata, e.rdata);
          chk({tag, ".drdata_hold"}, bus.DRdata, m_drdata);
          m_irdata = e.rdata;
          bus.IReq = 1'b0;
        end else begin
          chk({tag, ".drdata"}, bus.DRdata, e.rdata);
          chk({tag, ".irdata_hold"}, bus.IRdata, m_irdata);
          m_drdata = e.rdata;
          bus.DReq = 1'b0;
        end
        last_rdy = cyc;
        done++;
      end else if (bus.Err) begin
        chk({tag, ".err_without_ready"}, 32'(bus.Err), 32'h0);
      end
    end
    if (done < n_exp) chk({tag, ".round_budget"}, 32'(done), 32'(n_exp));
    @(posedge clk); #1;
    chk({tag, ".idle_after"}, 32'({bus.MemReq, bus.IReady, bus.DReady, bus.Err}), 32'h0);
  endtask

  // Requests held high continuously; n completions, zero-latency memory
  task automatic run_stream(input bit i_on, input bit d_on, input logic [31:0] ia, input logic [31:0] da,
                            input int n, input string tag);
    bit   q[$];
    bit   w, prev_mr;
    int   done, cyc, last_rdy;
    logic [31:0] idat, ddat;
    idat = 32'hA000_0000 | ia;  ddat = 32'hB000_0000 | da;
    lat_tab[ia] = 0; dat_tab[ia] = idat; lat_tab[da] = 0; dat_tab[da] = ddat;
    bus.IReq = i_on; bus.IAddr = ia; bus.DReq = d_on; bus.DWe = 1'b0; bus.DAddr = da;
    done = 0; cyc = 0; last_rdy = -1; prev_mr = 1'b0;
    while (done < n && cyc < 20 * n + 20) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.MemReq && !prev_mr) begin
        w = model_pick_i(i_on, d_on);
        model_note(w, i_on && d_on);
        q.push_back(w);
        chk({tag, ".memaddr"}, bus.MemAddr, w ? ia : da);
        if (last_rdy >= 0) chk({tag, ".regrant_gap"}, 32'(cyc - last_rdy), 32'd2);
      end
      prev_mr = bus.MemReq;
      if (bus.IReady || bus.DReady) begin
        if (q.size() == 0) begin
          chk({tag, ".unexpected_ready"}, 32'({bus.IReady, bus.DReady}), 32'h0);
        end else begin
          w = q.pop_front();
          chk({tag, ".grant_order"}, 32'({bus.IReady, bus.DReady}), w ? 32'd2 : 32'd1);
          chk({tag, ".rdata"}, w ? bus.IRdata : bus.DRdata, w ? idat : ddat);
          if (w) m_irdata = idat; else m_drdata = ddat;
        end
        if (last_rdy >= 0) chk({tag, ".completion_spacing"}, 32'(cyc - last_rdy), 32'd3);
        last_rdy = cyc;
        done++;
        if (done == n) begin bus.IReq = 1'b0; bus.DReq = 1'b0; end
      end
    end
    if (done < n) chk({tag, ".stream_budget"}, 32'(done), 32'(n));
    @(posedge clk); #1;
    chk({tag, ".idle_after"}, 32'({bus.MemReq, bus.IReady, bus.DReady}), 32'h0);
  endtask

  // No Ready, Err or MemReq for n cycles
  task automatic quiet(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk({tag, ".quiet"}, 32'({bus.MemReq, bus.IReady, bus.DReady, bus.Err}), 32'h0);
    end
  endtask

  initial begin
    vec_t   tbl[9];
    round_t r;
    exp_t   ei, ed;
    bit     fi;
    int     k, waitc;

    reset = 1'b1; mv_stray = 1'b0;
    bus.IReq = 1'b0; bus.IAddr = '0; bus.DReq = 1'b0; bus.DWe = 1'b0; bus.DAddr = '0; bus.DWdata = '0;
    m_streak = 0; m_irdata = '0; m_drdata = '0;

    tbl[0] = mk(1, 0, 32'h10, 32'h0,        32'hDEADBEEF, 2,  32'hDEADBEEF, 3, 0);
    tbl[1] = mk(0, 0, 32'h44, 32'h0,        32'hCAFEF00D, 1,  32'hCAFEF00D, 2, 0);
    tbl[2] = mk(0, 1, 32'h40, 32'h12345678, 32'h5A5A5A5A, 0,  32'hCAFEF00D, 1, 0);
    tbl[3] = mk(1, 0, 32'h20, 32'h0,        32'h0BADCAFE, 7,  32'h0BADCAFE, 8, 0);
    tbl[4] = mk(1, 0, 32'h24, 32'h0,        32'h99999999, -1, 32'h0,        8, 1);
    tbl[5] = mk(0, 1, 32'h50, 32'hAAAA5555, 32'h5A5A5A5A, -1, 32'h0,        8, 1);
    tbl[6] = mk(0, 0, 32'h54, 32'h0,        32'h11223344, 3,  32'h11223344, 4, 0);
    tbl[7] = mk(0, 0, 32'h58, 32'h0,        32'h77777777, -1, 32'h0,        8, 1);
    tbl[8] = mk(1, 0, 32'h28, 32'h0,        32'h76543210, 0,  32'h76543210, 1, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset.memreq_we", 32'({bus.MemReq, bus.MemWe}), 32'h0);
    chk("reset.memaddr", bus.MemAddr, 32'h0);
    chk("reset.memwdata", bus.MemWdata, 32'h0);
    chk("reset.ready_err", 32'({bus.IReady, bus.DReady, bus.Err}), 32'h0);
    chk("reset.irdata", bus.IRdata, 32'h0);
    chk("reset.drdata", bus.DRdata, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      model_note(tbl[i].is_i, 1'b0);
      run_round(tbl[i].r, tbl[i].is_i, tbl[i].e, tbl[i].e, $sformatf("vec%0d", i));
    end

    // Timeout followed by a stray late ack
    r = tbl[7].r; r.d_addr = 32'h60;
    ed = model_exp(0, 0, r.d_data, -1);
    model_note(1'b0, 1'b0);
    run_round(r, 1'b0, ed, ed, "tmo_stray");
    mv_stray = 1'b1;
    @(posedge clk); #1;
    mv_stray = 1'b0;
    quiet(4, "tmo_stray");
    chk("tmo_stray.drdata", bus.DRdata, 32'h0);

    run_stream(1, 1, 32'h100, 32'h200, 10, "contend");
    run_stream(1, 0, 32'h300, 32'h304, 3, "held_i");

    // Reset during the second BUSY cycle
    lat_tab[32'h400] = -1;
    bus.IReq = 1'b1; bus.IAddr = 32'h400;
    waitc = 0;
    do begin @(posedge clk); #1; waitc++; end while (!bus.MemReq && waitc < 10);
    chk("rst_mid.busy_reached", 32'(bus.MemReq), 32'h1);
    @(posedge clk); #1;
    reset = 1'b1; bus.IReq = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid.memreq_we", 32'({bus.MemReq, bus.MemWe}), 32'h0);
    chk("rst_mid.memaddr", bus.MemAddr, 32'h0);
    chk("rst_mid.ready_err", 32'({bus.IReady, bus.DReady, bus.Err}), 32'h0);
    chk("rst_mid.rdata", bus.IRdata | bus.DRdata, 32'h0);
    reset = 1'b0;
    m_streak = 0; m_irdata = '0; m_drdata = '0;
    mv_stray = 1'b1;
    @(posedge clk); #1;
    mv_stray = 1'b0;
    quiet(3, "rst_mid");
    r = tbl[0].r; r.i_addr = 32'h404; r.i_data = 32'h0DDC0FFE; r.i_lat = 1;
    ei = model_exp(1, 0, r.i_data, 1);
    model_note(1'b1, 1'b0);
    run_round(r, 1'b1, ei, ei, "rst_mid.after");

    // Randomized rounds against the model
    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(1, 3));
      r.i_on = k[0]; r.d_on = k[1];
      r.d_we    = 1'($urandom_range(0, 1));
      r.i_addr  = 32'h1000_0000 | ($urandom & 32'h0000_FFFC);
      r.d_addr  = 32'h2000_0000 | ($urandom & 32'h0000_FFFC);
      r.d_wdata = $urandom;
      r.i_data  = $urandom;
      r.d_data  = $urandom;
      k = int'($urandom_range(0, 7)); r.i_lat = (k == 0) ? -1 : ((k == 7) ? 7 : k - 1);
      k = int'($urandom_range(0, 7)); r.d_lat = (k == 0) ? -1 : ((k == 7) ? 7 : k - 1);
      fi = model_pick_i(r.i_on, r.d_on);
      model_note(fi, r.i_on && r.d_on);
      if (r.i_on && r.d_on) model_note(!fi, 1'b0);
      ei = model_exp(1, 1'b0, r.i_data, r.i_lat);
      ed = model_exp(0, r.d_we, r.d_data, r.d_lat);
      run_round(r, fi, fi ? ei : ed, fi ? ed : ei, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
